// File: rtl/load_store_sequencer.sv
// Hardwired fetch/decode/execute control sequencer for ld, ldi, st and halt on the bus datapath.
// Moore FSM: strobes decode state only; memory states hold until mem_ready, counter tracks retires.
module load_store_sequencer #(
  parameter int unsigned         BITS    = 32,
  parameter int unsigned         OPW     = 5,
  parameter int unsigned         CNT_W   = 16,
  parameter logic [OPW-1:0]      OP_LD   = 5'b00000,
  parameter logic [OPW-1:0]      OP_LDI  = 5'b00001,
  parameter logic [OPW-1:0]      OP_ST   = 5'b00010,
  parameter logic [OPW-1:0]      OP_HALT = 5'b11011
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BITS-1:0]  IRVal,
  input  logic             mem_ready,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             RZin,
  output logic             RZout,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Gra,
  output logic             Grb,
  output logic             Rin,
  output logic             Rout,
  output logic             BAout,
  output logic             Cout,
  output logic             RYin,
  output logic             ADD,
  output logic             Write,
  output logic             run,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, DEC, T3, T4, T5, T6, T7, ILL, HALT
  } state_t;

  state_t          state, next;
  logic [OPW-1:0]  ir_op, op_q;
  logic            retire;
  logic            unused_ir_bits;

  assign ir_op          = IRVal[BITS-1:BITS-OPW];
  assign unused_ir_bits = ^IRVal[BITS-OPW-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next;
  end

  // Opcode is latched in DEC so IR may change freely during execute.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            op_q <= '0;
    else if (state == DEC) op_q <= ir_op;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      instr_count <= '0;
    else if (retire) instr_count <= instr_count + 1'b1;
  end

  always_comb begin
    next       = state;
    retire     = 1'b0;
    PCout      = 1'b0;
    MARin      = 1'b0;
    IncPC      = 1'b0;
    RZin       = 1'b0;
    RZout      = 1'b0;
    PCin       = 1'b0;
    Read       = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    BAout      = 1'b0;
    Cout       = 1'b0;
    RYin       = 1'b0;
    ADD        = 1'b0;
    Write      = 1'b0;
    illegal_op = 1'b0;
    run        = (state != IDLE) && (state != HALT);

    case (state)
      IDLE: next = T0;
      T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; RZin = 1'b1;
        next  = T1;
      end
      T1: begin
        Read = 1'b1; MDRin = 1'b1; RZout = 1'b1; PCin = 1'b1;
        if (mem_ready) next = T2;
      end
      T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        next   = DEC;
      end
      DEC: begin
        if (ir_op == OP_LD || ir_op == OP_LDI || ir_op == OP_ST) begin
          next = T3;
        end else if (ir_op == OP_HALT) begin
          next   = HALT;
          retire = 1'b1;
        end else begin
          next = ILL;
        end
      end
      T3: begin
        Grb = 1'b1; BAout = 1'b1; RYin = 1'b1;
        next = T4;
      end
      T4: begin
        Cout = 1'b1; ADD = 1'b1; RZin = 1'b1;
        next = T5;
      end
      T5: begin
        RZout = 1'b1;
        if (op_q == OP_LDI) begin
          Gra = 1'b1; Rin = 1'b1;
          retire = 1'b1;
          next   = T0;
        end else begin
          MARin = 1'b1;
          next  = T6;
        end
      end
      T6: begin
        MDRin = 1'b1;
        if (op_q == OP_ST) begin
          Gra = 1'b1; Rout = 1'b1;
          next = T7;
        end else begin
          Read = 1'b1;
          if (mem_ready) next = T7;
        end
      end
      T7: begin
        if (op_q == OP_ST) begin
          Write = 1'b1;
          if (mem_ready) begin
            retire = 1'b1;
            next   = T0;
          end
        end else begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          retire = 1'b1;
          next   = T0;
        end
      end
      ILL: begin
        illegal_op = 1'b1;
        next       = T0;
      end
      HALT:    next = HALT;
      default: next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_sequencer.sv
// Directed-vector bench for load_store_sequencer: state-table strobe traces, memory waits,
// illegal opcode, halt, asynchronous reset mid-store and counter wrap on a narrow instance.
module tb_load_store_sequencer;

  localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010;
  localparam logic [4:0] HLT = 5'b11011, BAD = 5'b10101;

  localparam int PCOUT = 18, MARIN = 17, INCPC = 16, RZIN = 15, RZOUT = 14, PCIN = 13;
  localparam int READ = 12, MDRIN = 11, MDROUT = 10, IRIN = 9, GRA = 8, GRB = 7;
  localparam int RIN = 6, ROUT = 5, BAOUT = 4, COUT = 3, RYIN = 2, ADDB = 1, WRITE = 0;

  localparam logic [18:0] X_NONE = 19'd0;
  localparam logic [18:0] X_T0  = (19'd1<<PCOUT)|(19'd1<<MARIN)|(19'd1<<INCPC)|(19'd1<<RZIN);
  localparam logic [18:0] X_T1  = (19'd1<<READ)|(19'd1<<MDRIN)|(19'd1<<RZOUT)|(19'd1<<PCIN);
  localparam logic [18:0] X_T2  = (19'd1<<MDROUT)|(19'd1<<IRIN);
  localparam logic [18:0] X_T3  = (19'd1<<GRB)|(19'd1<<BAOUT)|(19'd1<<RYIN);
  localparam logic [18:0] X_T4  = (19'd1<<COUT)|(19'd1<<ADDB)|(19'd1<<RZIN);
  localparam logic [18:0] X_T5I = (19'd1<<RZOUT)|(19'd1<<GRA)|(19'd1<<RIN);
  localparam logic [18:0] X_T5M = (19'd1<<RZOUT)|(19'd1<<MARIN);
  localparam logic [18:0] X_T6L = (19'd1<<READ)|(19'd1<<MDRIN);
  localparam logic [18:0] X_T7L = (19'd1<<MDROUT)|(19'd1<<GRA)|(19'd1<<RIN);
  localparam logic [18:0] X_T6S = (19'd1<<GRA)|(19'd1<<ROUT)|(19'd1<<MDRIN);
  localparam logic [18:0] X_T7S = (19'd1<<WRITE);

  typedef struct {
    logic        rst;
    logic [4:0]  op;
    logic        mr;
    logic [18:0] s;
    logic        rn;
    logic        il;
    logic [15:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_ready = 1'b1;
  logic [31:0] IRVal = 32'd0;

  logic PCout, MARin, IncPC, RZin, RZout, PCin, Read, MDRin, MDRout, IRin;
  logic Gra, Grb, Rin, Rout, BAout, Cout, RYin, ADD, Write, run, illegal_op;
  logic [15:0] instr_count;
  logic [18:0] strobes;

  logic [18:0] unused_s4;
  logic        unused_run4, unused_ill4;
  logic [3:0]  cnt4;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  assign strobes = {PCout, MARin, IncPC, RZin, RZout, PCin, Read, MDRin, MDRout, IRin,
                    Gra, Grb, Rin, Rout, BAout, Cout, RYin, ADD, Write};

  load_store_sequencer dut (
    .clk(clk), .reset(reset), .IRVal(IRVal), .mem_ready(mem_ready),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .RZin(RZin), .RZout(RZout),
    .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Gra(Gra), .Grb(Grb), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .RYin(RYin), .ADD(ADD), .Write(Write), .run(run), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  load_store_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .IRVal(IRVal), .mem_ready(mem_ready),
    .PCout(unused_s4[18]), .MARin(unused_s4[17]), .IncPC(unused_s4[16]), .RZin(unused_s4[15]),
    .RZout(unused_s4[14]), .PCin(unused_s4[13]), .Read(unused_s4[12]), .MDRin(unused_s4[11]),
    .MDRout(unused_s4[10]), .IRin(unused_s4[9]), .Gra(unused_s4[8]), .Grb(unused_s4[7]),
    .Rin(unused_s4[6]), .Rout(unused_s4[5]), .BAout(unused_s4[4]), .Cout(unused_s4[3]),
    .RYin(unused_s4[2]), .ADD(unused_s4[1]), .Write(unused_s4[0]), .run(unused_run4),
    .illegal_op(unused_ill4), .instr_count(cnt4)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic [4:0] op, input logic mr,
                     input logic [18:0] s, input logic rn, input logic il, input int c);
    vec_t v;
    v.rst = r; v.op = op; v.mr = mr; v.s = s; v.rn = rn; v.il = il; v.cnt = 16'(c);
    vecs.push_back(v);
  endtask

  // Fetch, decode and effective-address phases with mem_ready held high.
  task automatic add_ea(input logic [4:0] op, input int c);
    add(1, op, 1, X_T0, 1, 0, c);
    add(1, op, 1, X_T1, 1, 0, c);
    add(1, op, 1, X_T2, 1, 0, c);
    add(1, op, 1, X_NONE, 1, 0, c);
    add(1, op, 1, X_T3, 1, 0, c);
    add(1, op, 1, X_T4, 1, 0, c);
  endtask

  task automatic tick(input logic r, input logic [4:0] op, input logic mr);
    reset     = r;
    IRVal     = {op, 27'($urandom)};
    mem_ready = mr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset, then ldi / ld / st back to back with mem_ready=1
    add(0, LDI, 1, X_NONE, 0, 0, 0);
    add(0, LDI, 1, X_NONE, 0, 0, 0);
    add_ea(LDI, 0);
    add(1, LDI, 1, X_T5I, 1, 0, 0);
    add_ea(LD, 1);
    add(1, LD, 1, X_T5M, 1, 0, 1);
    add(1, LD, 1, X_T6L, 1, 0, 1);
    add(1, LD, 1, X_T7L, 1, 0, 1);
    add_ea(ST, 2);
    add(1, ST, 1, X_T5M, 1, 0, 2);
    add(1, ST, 1, X_T6S, 1, 0, 2);
    add(1, ST, 1, X_T7S, 1, 0, 2);
    // illegal opcode: one-cycle pulse, no retire, straight back to T0
    add(1, BAD, 1, X_T0, 1, 0, 3);
    add(1, BAD, 1, X_T1, 1, 0, 3);
    add(1, BAD, 1, X_T2, 1, 0, 3);
    add(1, BAD, 1, X_NONE, 1, 0, 3);
    add(1, BAD, 1, X_NONE, 1, 1, 3);
    // ld with 4 wait cycles in T1 and 3 in T6 (16 cycles T0..T7)
    add(1, LD, 0, X_T0, 1, 0, 3);
    add(1, LD, 0, X_T1, 1, 0, 3);
    for (int i = 0; i < 4; i++) add(1, LD, 0, X_T1, 1, 0, 3);
    add(1, LD, 1, X_T2, 1, 0, 3);
    add(1, LD, 0, X_NONE, 1, 0, 3);
    add(1, LD, 0, X_T3, 1, 0, 3);
    add(1, LD, 0, X_T4, 1, 0, 3);
    add(1, LD, 0, X_T5M, 1, 0, 3);
    add(1, LD, 0, X_T6L, 1, 0, 3);
    for (int i = 0; i < 3; i++) add(1, LD, 0, X_T6L, 1, 0, 3);
    add(1, LD, 1, X_T7L, 1, 0, 3);
    // halt retires once on entry
    add(1, HLT, 0, X_T0, 1, 0, 4);
    add(1, HLT, 1, X_T1, 1, 0, 4);
    add(1, HLT, 1, X_T2, 1, 0, 4);
    add(1, HLT, 1, X_NONE, 1, 0, 4);
    add(1, HLT, 1, X_NONE, 0, 0, 5);

    foreach (vecs[i]) begin
      reset     = vecs[i].rst;
      IRVal     = {vecs[i].op, 27'(i * 32'h9E3779B)};
      mem_ready = vecs[i].mr;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), 64'({strobes, run, illegal_op, instr_count}),
          64'({vecs[i].s, vecs[i].rn, vecs[i].il, vecs[i].cnt}));
    end

    // halt is absorbing regardless of mem_ready
    for (int i = 0; i < 50; i++) begin
      tick(1, 5'($urandom), 1'(i));
      chk($sformatf("halt_hold%0d", i), 64'({strobes, run, instr_count}), 64'({19'd0, 1'b0, 16'd5}));
    end
    reset = 1'b0;
    #1;
    chk("halt_reset", 64'({strobes, run, instr_count}), 64'd0);
    tick(0, ST, 1);
    tick(1, ST, 1);
    chk("restart_t0", 64'({strobes, run}), 64'({X_T0, 1'b1}));

    // st interrupted by asynchronous reset during the Write wait
    for (int i = 0; i < 7; i++) tick(1, ST, 1);
    tick(1, ST, 0);
    chk("st_t7", 64'(strobes), 64'(X_T7S));
    tick(1, ST, 0);
    chk("st_t7_wait", 64'(strobes), 64'(X_T7S));
    #2 reset = 1'b0;
    #1;
    chk("async_write_drop", 64'({strobes, run, instr_count}), 64'd0);
    tick(0, ST, 0);
    chk("async_idle", 64'({strobes, run}), 64'd0);
    tick(1, ST, 1);
    chk("async_restart_t0", 64'({strobes, run, instr_count}), 64'({X_T0, 1'b1, 16'd0}));

    // 17 ldi: 4-bit counter wraps 15 -> 0 -> 1
    tick(0, LDI, 1);
    tick(1, LDI, 1);
    for (int n = 1; n <= 17; n++) begin
      for (int c = 0; c < 7; c++) tick(1, LDI, 1);
      chk($sformatf("ldi_cnt%0d", n), 64'(instr_count), 64'(n));
      if (n >= 15) chk($sformatf("wrap_cnt%0d", n), 64'(cnt4), 64'(n % 16));
    end
    chk("ldi_back_t0", 64'(strobes), 64'(X_T0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
